mnist_batch_sched: RTL and testbench
====================================

MNIST_BATCH_SCHED -- requirements
Module: mnist_batch_sched

Interface
REQ-001 Parameter NUM_IMG, default 3: number of embedded images run per batch; legal range 1..3.
REQ-002 Parameter LABELS, default 12'h326: expected digit per image; image k in nibble [4k+3:4k], so image0=6, image1=2, image2=3.
REQ-003 Parameter TIMEOUT, default 2500000: maximum cycles waited for acc_done per image (100 ms at 25 MHz).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset; the block is in reset while rst=0.
REQ-006 go  input  1  batch start request, sampled in IDLE only.
REQ-007 abort  input  1  terminates a running batch.
REQ-008 acc_start  output  1  one-cycle start pulse to the inference core.
REQ-009 acc_img_sel  output  2  image index presented to the inference core.
REQ-010 acc_valid  input  1  core reports that acc_img_sel is a legal image.
REQ-011 acc_done  input  1  core completion level; stays high until the core returns to idle.
REQ-012 acc_digit  input  4  predicted digit; valid while acc_done=1.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 batch_done  output  1  one-cycle pulse when a batch ends by any cause.
REQ-015 pass_cnt  output  2  number of images whose prediction matched LABELS.
REQ-016 fail_mask  output  3  bit k set when image k failed, was invalid, or timed out.
REQ-017 timeout_err  output  1  sticky flag: an image exceeded TIMEOUT.
REQ-018 aborted  output  1  sticky flag: the batch was ended by abort.
REQ-019 last_digit  output  4  most recent captured acc_digit.

Function
REQ-020 The FSM SHALL have seven states: IDLE, SEL, FIRE, WAIT, CHECK, RELEASE and FINISH.
REQ-021 In IDLE with go=1, the block SHALL clear idx, pass_cnt, fail_mask, timeout_err and aborted, then enter SEL.
REQ-022 In SEL, acc_img_sel SHALL equal idx, with one settle cycle; if acc_valid=1 the FSM SHALL go to FIRE, otherwise it SHALL set fail_mask[idx] and go to RELEASE.
REQ-023 FIRE SHALL assert acc_start for exactly one cycle, clear the 22-bit timer, and go to WAIT.
REQ-024 acc_start SHALL be 0 in every state other than FIRE.
REQ-025 acc_img_sel SHALL hold idx from SEL until idx changes.
REQ-026 In WAIT, the timer SHALL increment each cycle; acc_done=1 SHALL capture acc_digit into last_digit and move to CHECK.
REQ-027 If timer reaches TIMEOUT-1 with acc_done=0, the block SHALL set timeout_err and fail_mask[idx] and go to FINISH; remaining images are not run.
REQ-028 If acc_done and timeout occur in the same cycle, acc_done SHALL win.
REQ-029 CHECK SHALL compare last_digit with LABELS nibble idx: on a match, pass_cnt increments by 1 (saturating at 3); otherwise fail_mask[idx] is set.
REQ-030 RELEASE SHALL wait for acc_done=0 before leaving, so a stale done is never counted for the next image.
REQ-031 On leaving RELEASE: if idx=NUM_IMG-1, the FSM SHALL go to FINISH; otherwise idx increments and the FSM goes to SEL.
REQ-032 FINISH SHALL pulse batch_done for one cycle, then return to IDLE.
REQ-033 pass_cnt, fail_mask, timeout_err, aborted and last_digit SHALL hold their values in IDLE until the next accepted go.
REQ-034 abort=1 in any state other than IDLE or FINISH SHALL set aborted and force FINISH on the next edge; no further acc_start is issued.
REQ-035 abort has priority over every other transition condition.
REQ-036 abort in IDLE SHALL have no effect.
REQ-037 go=1 while busy=1 SHALL be ignored; go held high through FINISH SHALL start a new batch only after IDLE is entered.
REQ-038 From an accepted go to the first acc_start SHALL be exactly 2 cycles: IDLE→SEL, then SEL→FIRE.

Reset
REQ-039 rst=0 SHALL immediately force the FSM to IDLE, and SHALL force idx, timer, acc_start, acc_img_sel, busy, batch_done, pass_cnt, fail_mask, timeout_err, aborted and last_digit to 0.
REQ-040 Reset asserted mid-batch SHALL drop acc_start and busy without waiting for a clock edge.
REQ-041 After rst returns to 1, the block SHALL wait for a fresh go.

Verification
REQ-042 Nominal batch: go pulse with a core model returning 6,2,3 → three acc_start pulses with sel 0,1,2; then batch_done, pass_cnt=3, fail_mask=000, timeout_err=0.
REQ-043 Mismatch: the model returns 6,7,3 → pass_cnt=2, fail_mask=010, last_digit=3.
REQ-044 Invalid select: NUM_IMG=3 with acc_valid forced 0 for sel=1 → no acc_start issued for image 1, fail_mask=010, pass_cnt=2.
REQ-045 Timeout: TIMEOUT=50 and acc_done never rises for image 0 → timeout_err=1, fail_mask=001, batch_done exactly 50 cycles after acc_start, and no further starts.
REQ-046 Abort and reset: abort during WAIT of image 1 → aborted=1, batch_done next cycle, pass_cnt=1. Separately, rst=0 during WAIT → all outputs 0 asynchronously; a following go runs a clean batch.
REQ-047 Handshake: acc_done held high 5 cycles after each result → each image counted once, and no acc_start is issued while acc_done=1.

Source files
------------

// File: rtl/mnist_batch_sched.sv
// Batch sequencer for the embedded MNIST images: selects each image, fires the
// inference core, checks the predicted digit against LABELS and reports the tally.
module mnist_batch_sched #(
    parameter int unsigned NUM_IMG = 3,
    parameter logic [11:0] LABELS  = 12'h326,
    parameter int unsigned TIMEOUT = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       abort,
    output logic       acc_start,
    output logic [1:0] acc_img_sel,
    input  logic       acc_valid,
    input  logic       acc_done,
    input  logic [3:0] acc_digit,
    output logic       busy,
    output logic       batch_done,
    output logic [1:0] pass_cnt,
    output logic [2:0] fail_mask,
    output logic       timeout_err,
    output logic       aborted,
    output logic [3:0] last_digit
);

    typedef enum logic [2:0] {
        IDLE, SEL, FIRE, WAIT, CHECK, RELEASE, FINISH
    } state_t;

    localparam logic [1:0]  LAST_IDX = 2'(NUM_IMG - 1);
    localparam logic [21:0] TO_LAST  = 22'(TIMEOUT - 1);
    localparam logic [15:0] LAB      = {4'h0, LABELS};

    state_t      state, state_nxt;
    logic [1:0]  idx;
    logic [21:0] timer;
    logic [3:0]  label_nib;
    logic [2:0]  idx_bit;

    logic clr_batch, set_fail, set_tmo, set_abort, capture;
    logic inc_pass, inc_idx, clr_timer, inc_timer;

    assign label_nib   = LAB[{idx, 2'b00} +: 4];
    assign idx_bit     = 3'(4'b0001 << idx);
    assign acc_start   = (state == FIRE);
    assign busy        = (state != IDLE);
    assign batch_done  = (state == FINISH);
    assign acc_img_sel = idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr_batch = 1'b0;
        set_fail  = 1'b0;
        set_tmo   = 1'b0;
        set_abort = 1'b0;
        capture   = 1'b0;
        inc_pass  = 1'b0;
        inc_idx   = 1'b0;
        clr_timer = 1'b0;
        inc_timer = 1'b0;
        case (state)
            IDLE: if (go) begin
                clr_batch = 1'b1;
                state_nxt = SEL;
            end
            SEL: if (acc_valid) begin
                state_nxt = FIRE;
            end else begin
                set_fail  = 1'b1;
                state_nxt = RELEASE;
            end
            FIRE: begin
                clr_timer = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                inc_timer = 1'b1;
                // Timeout fires on the edge where the timer reaches TIMEOUT-1
                if (acc_done) begin
                    capture   = 1'b1;
                    state_nxt = CHECK;
                end else if ((timer + 22'd1) >= TO_LAST) begin
                    set_tmo   = 1'b1;
                    set_fail  = 1'b1;
                    state_nxt = FINISH;
                end
            end
            CHECK: begin
                if (last_digit == label_nib) inc_pass = 1'b1;
                else                         set_fail = 1'b1;
                state_nxt = RELEASE;
            end
            RELEASE: if (!acc_done) begin
                if (idx == LAST_IDX) begin
                    state_nxt = FINISH;
                end else begin
                    inc_idx   = 1'b1;
                    state_nxt = SEL;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Abort overrides every transition and suppresses the state's own updates
        if (abort && state != IDLE && state != FINISH) begin
            state_nxt = FINISH;
            set_abort = 1'b1;
            set_fail  = 1'b0;
            set_tmo   = 1'b0;
            capture   = 1'b0;
            inc_pass  = 1'b0;
            inc_idx   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx         <= '0;
            timer       <= '0;
            pass_cnt    <= '0;
            fail_mask   <= '0;
            timeout_err <= 1'b0;
            aborted     <= 1'b0;
            last_digit  <= '0;
        end else begin
            if (clr_batch) begin
                idx         <= '0;
                pass_cnt    <= '0;
                fail_mask   <= '0;
                timeout_err <= 1'b0;
                aborted     <= 1'b0;
            end
            if (inc_idx)   idx <= idx + 2'd1;
            if (clr_timer) timer <= '0;
            else if (inc_timer) timer <= timer + 22'd1;
            if (set_fail)  fail_mask <= fail_mask | idx_bit;
            if (set_tmo)   timeout_err <= 1'b1;
            if (set_abort) aborted <= 1'b1;
            if (capture)   last_digit <= acc_digit;
            if (inc_pass && pass_cnt != 2'd3) pass_cnt <= pass_cnt + 2'd1;
        end
    end

endmodule

// File: tb/tb_mnist_batch_sched.sv
// Directed bench for mnist_batch_sched with a behavioural inference-core model.
module tb_mnist_batch_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       go = 1'b0;
    logic       abort = 1'b0;
    logic       acc_start;
    logic [1:0] acc_img_sel;
    logic       acc_valid;
    logic       acc_done = 1'b0;
    logic [3:0] acc_digit = 4'h0;
    logic       busy;
    logic       batch_done;
    logic [1:0] pass_cnt;
    logic [2:0] fail_mask;
    logic       timeout_err;
    logic       aborted;
    logic [3:0] last_digit;

    // core model knobs
    logic [15:0] resp = 16'h0326;
    logic [3:0]  valid_mask = 4'hF;
    logic        no_resp = 1'b0;
    logic        mclr = 1'b0;
    int unsigned lat = 2;
    int unsigned hold = 1;

    // core model state and monitors
    logic        pending = 1'b0;
    logic [1:0]  cur_sel = 2'd0;
    int unsigned lat_cnt = 0;
    int unsigned hold_cnt = 0;
    int unsigned starts = 0;
    logic [7:0]  sel_hist = 8'h00;
    logic        start_while_done = 1'b0;
    int unsigned cyc = 0;
    int unsigned last_start_cyc = 0;
    int unsigned bd_cyc = 0;
    int unsigned bd_cnt = 0;

    int total = 0;
    int bad = 0;

    mnist_batch_sched #(
        .NUM_IMG(3),
        .LABELS (12'h326),
        .TIMEOUT(50)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .abort      (abort),
        .acc_start  (acc_start),
        .acc_img_sel(acc_img_sel),
        .acc_valid  (acc_valid),
        .acc_done   (acc_done),
        .acc_digit  (acc_digit),
        .busy       (busy),
        .batch_done (batch_done),
        .pass_cnt   (pass_cnt),
        .fail_mask  (fail_mask),
        .timeout_err(timeout_err),
        .aborted    (aborted),
        .last_digit (last_digit)
    );

    always #5 clk = ~clk;

    assign acc_valid = valid_mask[acc_img_sel];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mclr || !rst) begin
            pending          <= 1'b0;
            acc_done         <= 1'b0;
            starts           <= 0;
            sel_hist         <= 8'h00;
            start_while_done <= 1'b0;
            bd_cnt           <= 0;
        end else begin
            if (acc_done) begin
                if (hold_cnt <= 1) acc_done <= 1'b0;
                else               hold_cnt <= hold_cnt - 1;
            end
            if (acc_start) begin
                starts         <= starts + 1;
                sel_hist       <= {sel_hist[5:0], acc_img_sel};
                last_start_cyc <= cyc;
                if (acc_done) start_while_done <= 1'b1;
                if (!no_resp) begin
                    pending <= 1'b1;
                    lat_cnt <= lat;
                    cur_sel <= acc_img_sel;
                end
            end else if (pending) begin
                if (lat_cnt <= 1) begin
                    pending   <= 1'b0;
                    acc_done  <= 1'b1;
                    acc_digit <= resp[{cur_sel, 2'b00} +: 4];
                    hold_cnt  <= hold;
                end else begin
                    lat_cnt <= lat_cnt - 1;
                end
            end
            if (batch_done) begin
                bd_cnt <= bd_cnt + 1;
                bd_cyc <= cyc;
            end
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_test;
        mclr = 1'b1;
        tick;
        mclr = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            tick;
            if (batch_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_bd_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (2) tick;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(acc_start), 32'd0);
        chk("rst_pass", 32'(pass_cnt), 32'd0);
        chk("rst_fail", 32'(fail_mask), 32'd0);
        chk("rst_last", 32'(last_digit), 32'd0);
        rst = 1'b1;
        tick;

        // nominal batch, go-to-start latency
        new_test;
        go = 1'b1;
        tick;
        go = 1'b0;
        chk("lat_busy", 32'(busy), 32'd1);
        chk("lat_nostart", 32'(acc_start), 32'd0);
        tick;
        chk("lat_fire", 32'(acc_start), 32'd1);
        wait_done("nom");
        chk("nom_pass", 32'(pass_cnt), 32'd3);
        chk("nom_fail", 32'(fail_mask), 32'd0);
        chk("nom_tmo", 32'(timeout_err), 32'd0);
        chk("nom_starts", starts, 32'd3);
        chk("nom_sels", 32'(sel_hist), 32'h06);
        chk("nom_last", 32'(last_digit), 32'd3);
        tick;
        chk("nom_bd_pulse", 32'(batch_done), 32'd0);
        chk("nom_idle", 32'(busy), 32'd0);
        chk("nom_hold_pass", 32'(pass_cnt), 32'd3);

        // mismatch on image 1
        new_test;
        resp = 16'h0376;
        go = 1'b1;
        tick;
        go = 1'b0;
        wait_done("mis");
        chk("mis_pass", 32'(pass_cnt), 32'd2);
        chk("mis_fail", 32'(fail_mask), 32'b010);
        chk("mis_last", 32'(last_digit), 32'd3);

        // invalid select for image 1
        new_test;
        resp = 16'h0326;
        valid_mask = 4'b1101;
        go = 1'b1;
        tick;
        go = 1'b0;
        wait_done("inv");
        chk("inv_pass", 32'(pass_cnt), 32'd2);
        chk("inv_fail", 32'(fail_mask), 32'b010);
        chk("inv_starts", starts, 32'd2);
        chk("inv_sels", 32'(sel_hist), 32'h02);
        valid_mask = 4'hF;
        tick;

        // timeout on image 0
        new_test;
        no_resp = 1'b1;
        go = 1'b1;
        tick;
        go = 1'b0;
        wait_done("tmo");
        chk("tmo_err", 32'(timeout_err), 32'd1);
        chk("tmo_fail", 32'(fail_mask), 32'b001);
        chk("tmo_pass", 32'(pass_cnt), 32'd0);
        tick;
        chk("tmo_latency", bd_cyc - last_start_cyc, 32'd50);
        repeat (5) tick;
        chk("tmo_starts", starts, 32'd1);
        no_resp = 1'b0;

        // abort during WAIT of image 1
        new_test;
        lat = 10;
        go = 1'b1;
        tick;
        go = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (starts >= 2) break;
            tick;
        end
        chk("abt_reach", 32'(starts >= 2), 32'd1);
        repeat (2) tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abt_bd", 32'(batch_done), 32'd1);
        chk("abt_flag", 32'(aborted), 32'd1);
        chk("abt_pass", 32'(pass_cnt), 32'd1);
        chk("abt_fail", 32'(fail_mask), 32'd0);
        repeat (15) tick;
        chk("abt_starts", starts, 32'd2);
        abort = 1'b1;
        repeat (3) tick;
        abort = 1'b0;
        chk("abt_idle_noeffect", 32'(busy), 32'd0);
        chk("abt_sticky", 32'(aborted), 32'd1);
        chk("abt_hold_last", 32'(last_digit), 32'd6);

        // asynchronous reset while FIRE is driving acc_start
        new_test;
        lat = 2;
        go = 1'b1;
        tick;
        go = 1'b0;
        tick;
        chk("ar_pre_fire", 32'(acc_start), 32'd1);
        rst = 1'b0;
        #1;
        chk("ar_start", 32'(acc_start), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_pass", 32'(pass_cnt), 32'd0);
        chk("ar_last", 32'(last_digit), 32'd0);
        chk("ar_aborted", 32'(aborted), 32'd0);
        tick;
        rst = 1'b1;
        repeat (3) tick;
        chk("ar_wait_go", 32'(busy), 32'd0);
        new_test;
        go = 1'b1;
        tick;
        go = 1'b0;
        wait_done("ar_clean");
        chk("ar_clean_pass", 32'(pass_cnt), 32'd3);
        chk("ar_clean_fail", 32'(fail_mask), 32'd0);

        // done held 5 cycles, stray go while busy
        new_test;
        hold = 5;
        go = 1'b1;
        tick;
        go = 1'b0;
        repeat (6) tick;
        go = 1'b1;
        tick;
        go = 1'b0;
        wait_done("hs");
        chk("hs_pass", 32'(pass_cnt), 32'd3);
        chk("hs_fail", 32'(fail_mask), 32'd0);
        chk("hs_starts", starts, 32'd3);
        chk("hs_no_start_on_done", 32'(start_while_done), 32'd0);
        tick;
        chk("hs_one_batch", bd_cnt, 32'd1);
        chk("hs_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
